// File: rtl/proc_pkg.sv
// Shared definitions for the simple processor, its instruction memory and
// the instruction-fetch sequencer that sits between them.
package proc_pkg;

  localparam int PROC_DATA_W = 9;
  localparam int PROC_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_lat_cnt.sv
// Down-counter that times a synchronous memory read: loaded with the read
// latency when a fetch starts, it reports done once that many clocks have
// elapsed so the fetch FSM can capture the returned word on the next edge.
module fetch_lat_cnt #(
  parameter int MEM_LATENCY = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic clr_i,
  output logic done_o
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins over clear; otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(MEM_LATENCY);
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch sequencer: walks the program counter through a
// synchronous instruction memory, captures each returned word into DIN and
// holds it with Valid until the processor signals Advance. Supports PC load
// (jump/restart), wrap-or-halt at the last program address and Enable gating.
module instr_fetch
  import proc_pkg::*;
#(
  parameter int DATA_W      = PROC_DATA_W,
  parameter int ADDR_W      = PROC_ADDR_W,
  parameter int LAST_ADDR   = 2**ADDR_W - 1,
  parameter int MEM_LATENCY = 1,
  parameter bit WRAP        = 1'b1
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Enable,
  input  logic              Advance,
  input  logic              Load,
  input  logic [ADDR_W-1:0] LoadAddr,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [DATA_W-1:0] MemData,
  output logic [DATA_W-1:0] DIN,
  output logic              Valid,
  output logic              Halted,
  output logic [ADDR_W-1:0] PC
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] maddr_q;
  logic [DATA_W-1:0] din_q, din_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic              cnt_load, cnt_clr, lat_done;

  fetch_lat_cnt #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_lat_cnt (
    .clk_i (Clock),
    .rst_ni(Resetn),
    .load_i(cnt_load),
    .clr_i (cnt_clr),
    .done_o(lat_done)
  );

  // Next-state logic; Load overrides everything, including Advance.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    din_d    = din_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    cnt_load = 1'b0;
    cnt_clr  = 1'b0;
    if (Load) begin
      // Any read in flight is abandoned: the counter restarts for the new PC.
      pc_d     = LoadAddr;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      cnt_clr  = 1'b1;
      if (Enable) begin
        state_d  = FETCH;
        cnt_load = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (Enable) begin
            state_d  = FETCH;
            cnt_load = 1'b1;
          end
        end
        FETCH: begin
          // Enable is not looked at here so a started read always completes.
          if (lat_done) begin
            din_d   = MemData;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (Advance) begin
            valid_d = 1'b0;
            if ((pc_q == LAST) && !WRAP) begin
              halted_d = 1'b1;
              state_d  = HALT;
            end else begin
              pc_d     = (pc_q == LAST) ? '0 : pc_q + ADDR_W'(1);
              state_d  = Enable ? FETCH : IDLE;
              cnt_load = Enable;
            end
          end
        end
        HALT: begin
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, PC, memory address and output word registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      maddr_q  <= '0;
      din_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      maddr_q  <= pc_d;
      din_q    <= din_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign MemAddr = maddr_q;
  assign DIN     = din_q;
  assign Valid   = valid_q;
  assign Halted  = halted_q;
  assign PC      = pc_q;

endmodule
